// File: rtl/bcd_up_scorer_if.sv
// Bonus-addition handshake bundle for bcd_up_scorer.
// The requester owns valid/bcd; the scorer answers with ready/busy.
interface bcd_up_scorer_if;
  logic       valid;
  logic [7:0] bcd;
  logic       ready;
  logic       busy;

  modport master (
    output valid,
    output bcd,
    input  ready,
    input  busy
  );

  modport slave (
    input  valid,
    input  bcd,
    output ready,
    output busy
  );
endinterface

// File: rtl/bcd_up_scorer.sv
// 6-digit BCD score/distance up-counter with serial bonus additions.
// Define SCORE_SATURATE_EN to pin at 999999 on overflow instead of wrapping.
module bcd_up_scorer #(
  parameter logic [3:0] STEP = 4'h1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            enable1_i,
  input  logic            enable2_i,
  input  logic            tick_i,
  bcd_up_scorer_if.slave  add_if,
  output logic [3:0]      count1_o,
  output logic [3:0]      count2_o,
  output logic [3:0]      count3_o,
  output logic [3:0]      count4_o,
  output logic [3:0]      count5_o,
  output logic [3:0]      count6_o,
  output logic            sat_o
);

  typedef enum logic {
    IDLE,
    ADD
  } state_e;

  state_e          state_q, state_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      pend_q, pend_d;
  logic            carry_q, carry_d;
  logic [7:0]      add_q, add_d;
  logic            sat_q, sat_d;

  logic            eff_tick;
  logic            ready;
  logic [5:0][3:0] inc;
  logic            inc_co;
  logic [3:0]      cur;
  logic [3:0]      addend;
  logic [4:0]      dsum;
  logic [3:0]      dnew;
  logic            dco;
  logic            ov;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  assign eff_tick = tick_i && enable1_i && enable2_i;
  assign ready    = (state_q == IDLE) && (pend_q == 3'd0) && !clear_i;

  // Whole-value +STEP with the carry rippling through all six digits.
  always_comb begin
    logic       c;
    logic [4:0] s;
    c   = 1'b0;
    s   = 5'd0;
    inc = dig_q;
    for (int k = 0; k < 6; k++) begin
      s = {1'b0, dig_q[k]} + {4'd0, c};
      if (k == 0) s = s + {1'b0, STEP};
      if (s > 5'd9) begin
        inc[k] = 4'(s - 5'd10);
        c      = 1'b1;
      end else begin
        inc[k] = s[3:0];
        c      = 1'b0;
      end
    end
    inc_co = c;
  end

  // One digit of the serial bonus addition.
  always_comb begin
    cur = 4'd0;
    for (int k = 0; k < 6; k++) begin
      if (idx_q == 3'(k)) cur = dig_q[k];
    end
    unique case (1'b1)
      (idx_q == 3'd0): addend = add_q[3:0];
      (idx_q == 3'd1): addend = add_q[7:4];
      default:         addend = 4'd0;
    endcase
    dsum = {1'b0, cur} + {1'b0, addend} + {4'd0, carry_q};
    dco  = (dsum > 5'd9);
    dnew = dco ? 4'(dsum - 5'd10) : dsum[3:0];
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    carry_d = carry_q;
    add_d   = add_q;
    ov      = 1'b0;
`ifdef SCORE_SATURATE_EN
    sat_d   = sat_q;
`else
    sat_d   = 1'b0;
`endif

    if (clear_i) begin
      state_d = IDLE;
      dig_d   = '0;
      idx_d   = 3'd0;
      pend_d  = 3'd0;
      carry_d = 1'b0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (eff_tick || pend_q != 3'd0) begin
            dig_d  = inc;
            ov     = inc_co;
            pend_d = eff_tick ? pend_q : pend_q - 3'd1;
          end
          if (add_if.valid && ready) begin
            add_d   = {clamp9(add_if.bcd[7:4]), clamp9(add_if.bcd[3:0])};
            idx_d   = 3'd0;
            carry_d = 1'b0;
            state_d = ADD;
          end
        end
        ADD: begin
          for (int k = 0; k < 6; k++) begin
            if (idx_q == 3'(k)) dig_d[k] = dnew;
          end
          carry_d = dco;
          if (eff_tick && pend_q != 3'd7) pend_d = pend_q + 3'd1;
          if (idx_q == 3'd5) begin
            ov      = dco;
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase

`ifdef SCORE_SATURATE_EN
      // Once saturated the value is pinned; the FSM still runs its course.
      if (sat_q) dig_d = dig_q;
      if (ov) begin
        dig_d = {6{4'h9}};
        sat_d = 1'b1;
      end
`else
      sat_d = ov;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      idx_q   <= 3'd0;
      pend_q  <= 3'd0;
      carry_q <= 1'b0;
      add_q   <= 8'd0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      carry_q <= carry_d;
      add_q   <= add_d;
      sat_q   <= sat_d;
    end
  end

  assign add_if.ready = ready;
  assign add_if.busy  = (state_q == ADD);

  assign count1_o = dig_q[0];
  assign count2_o = dig_q[1];
  assign count3_o = dig_q[2];
  assign count4_o = dig_q[3];
  assign count5_o = dig_q[4];
  assign count6_o = dig_q[5];
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_bcd_up_scorer.sv
// Self-checking bench for bcd_up_scorer against an integer score model.
// Works with or without SCORE_SATURATE_EN defined.
module tb_bcd_up_scorer;

  localparam int STEP_I = 1;
  localparam int MODV   = 1000000;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       en1;
  logic       en2;
  logic       tick;
  logic [3:0] c1, c2, c3, c4, c5, c6;
  logic       sat;

  int checks;
  int errors;

  int m_val;
  int m_pend;
  int m_cnt;
  int m_addv;
  bit m_sat;

  bcd_up_scorer_if ifc ();

  bcd_up_scorer #(.STEP(4'(STEP_I))) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .enable1_i (en1),
    .enable2_i (en2),
    .tick_i    (tick),
    .add_if    (ifc),
    .count1_o  (c1),
    .count2_o  (c2),
    .count3_o  (c3),
    .count4_o  (c4),
    .count5_o  (c5),
    .count6_o  (c6),
    .sat_o     (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dut_value();
    return int'(c6) * 100000 + int'(c5) * 10000 + int'(c4) * 1000 +
           int'(c3) * 100 + int'(c2) * 10 + int'(c1);
  endfunction

  function automatic int clamp_val(input logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic void model_reset();
    m_val  = 0;
    m_pend = 0;
    m_cnt  = 0;
    m_addv = 0;
    m_sat  = 1'b0;
  endfunction

  function automatic void model_step(input bit tk, input bit av,
                                     input logic [7:0] ab, input bit clr);
    bit eff;
    bit ov;
    ov  = 1'b0;
    eff = tk && en1 && en2;
    if (clr) begin
      model_reset();
      return;
    end
    if (m_cnt == 0) begin
      bit rdy;
      rdy = (m_pend == 0);
      if (eff || m_pend > 0) begin
        m_val = m_val + STEP_I;
        if (!eff) m_pend--;
      end
      if (av && rdy) begin
        m_addv = clamp_val(ab);
        m_cnt  = 6;
      end
    end else begin
      if (eff && m_pend < 7) m_pend++;
      m_cnt--;
      if (m_cnt == 0) m_val = m_val + m_addv;
    end
    ov = (m_val >= MODV);
`ifdef SCORE_SATURATE_EN
    if (ov) begin
      m_val = MODV - 1;
      m_sat = 1'b1;
    end
`else
    if (ov) m_val = m_val - MODV;
    m_sat = ov;
`endif
  endfunction

  task automatic cyc(input bit tk, input bit av, input logic [7:0] ab,
                     input bit clr);
    @(negedge clk);
    tick      = tk;
    ifc.valid = av;
    ifc.bcd   = ab;
    clear     = clr;
    @(posedge clk);
    model_step(tk, av, ab, clr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dut_value() !== 0 || sat !== 1'b0 || ifc.busy !== 1'b0 ||
        ifc.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: val=%0d sat=%b busy=%b ready=%b exp 0/0/0/1",
               dut_value(), sat, ifc.busy, ifc.ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(1);
    checks++;
    if (dut_value() !== 0 || ifc.ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: val=%0d ready=%b exp 0/1",
               dut_value(), ifc.ready);
    end
  endtask

  task automatic test_tick();
    en1 = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (c2 !== 4'd1 || c1 !== 4'd2 || dut_value() !== m_val) begin
      errors++;
      $display("FAIL tick12: got %0d exp 12 (model %0d)", dut_value(), m_val);
    end
    en2 = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    en2 = 1'b1;
    en1 = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    en1 = 1'b1;
    checks++;
    if (dut_value() !== 12) begin
      errors++;
      $display("FAIL tick_gated: got %0d exp 12", dut_value());
    end
  endtask

  task automatic test_add_basic();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h95, 1'b0);
    idle(6);
    checks++;
    if (dut_value() !== 95) begin
      errors++;
      $display("FAIL add95: got %0d exp 95", dut_value());
    end
    cyc(1'b0, 1'b1, 8'h07, 1'b0);
    checks++;
    if (ifc.busy !== 1'b1 || ifc.ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b ready=%b exp 1/0", ifc.busy, ifc.ready);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (ifc.busy !== (i < 6)) begin
        errors++;
        $display("FAIL busy_len cycle %0d: busy=%b exp %b", i, ifc.busy,
                 (i < 6));
      end
    end
    checks++;
    if (dut_value() !== 102 || ifc.ready !== 1'b1 || dut_value() !== m_val) begin
      errors++;
      $display("FAIL add07: got %0d ready=%b exp 102 ready=1",
               dut_value(), ifc.ready);
    end
  endtask

  task automatic test_pending();
    int exp_v;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h10, 1'b0);
    idle(6);
    cyc(1'b0, 1'b1, 8'h99, 1'b0);
    for (int i = 1; i <= 6; i++) cyc(i <= 3, 1'b0, 8'h00, 1'b0);
    checks++;
    if (ifc.busy !== 1'b0 || dut_value() !== 109 || ifc.ready !== 1'b0) begin
      errors++;
      $display("FAIL pend_end: val=%0d busy=%b ready=%b exp 109/0/0",
               dut_value(), ifc.busy, ifc.ready);
    end
    exp_v = 109;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b1, 8'h01, 1'b0);
      exp_v++;
      checks++;
      if (dut_value() !== exp_v || ifc.ready !== (i == 3) ||
          ifc.busy !== 1'b0) begin
        errors++;
        $display("FAIL pend_drain %0d: val=%0d ready=%b exp %0d ready=%b",
                 i, dut_value(), ifc.ready, exp_v, (i == 3));
      end
    end
  endtask

  task automatic test_clamp();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'hFA, 1'b0);
    idle(6);
    checks++;
    if (dut_value() !== 99) begin
      errors++;
      $display("FAIL clamp: got %0d exp 99", dut_value());
    end
  endtask

  task automatic test_clear_mid();
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    idle(3);
    cyc(1'b1, 1'b1, 8'h22, 1'b1);
    checks++;
    if (dut_value() !== 0 || ifc.busy !== 1'b0 || sat !== 1'b0 ||
        ifc.ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid: val=%0d busy=%b sat=%b ready=%b exp 0/0/0/0",
               dut_value(), ifc.busy, sat, ifc.ready);
    end
    idle(1);
    checks++;
    if (ifc.ready !== 1'b1 || dut_value() !== 0) begin
      errors++;
      $display("FAIL clear_after: ready=%b val=%0d exp 1/0",
               ifc.ready, dut_value());
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b1, 8'h42, 1'b0);
    idle(2);
    @(negedge clk);
    ifc.valid = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_value() !== 0 || ifc.busy !== 1'b0 || ifc.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: val=%0d busy=%b ready=%b exp 0/0/1",
               dut_value(), ifc.busy, ifc.ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit tk, av, cl;
    logic [7:0] ab;
    for (int n = 0; n < 600; n++) begin
      en1 = ($urandom_range(0, 7) != 0);
      en2 = ($urandom_range(0, 7) != 0);
      tk  = $urandom_range(0, 1);
      av  = ($urandom_range(0, 2) == 0);
      ab  = 8'($urandom);
      cl  = ($urandom_range(0, 59) == 0);
      cyc(tk, av, ab, cl);
      checks++;
      if (ifc.busy !== (m_cnt != 0) || sat !== m_sat ||
          ifc.ready !== (m_cnt == 0 && m_pend == 0 && !cl) ||
          (m_cnt == 0 && dut_value() !== m_val)) begin
        errors++;
        $display("FAIL random %0d: val=%0d busy=%b ready=%b sat=%b exp val=%0d busy=%b pend=%0d sat=%b",
                 n, dut_value(), ifc.busy, ifc.ready, sat, m_val,
                 (m_cnt != 0), m_pend, m_sat);
      end
    end
    en1 = 1'b1;
    en2 = 1'b1;
  endtask

  task automatic test_overflow();
    int exp_v;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    // 99 added plus one tick on the accept edge: +100 per 7 cycles.
    for (int r = 0; r < 9999; r++) begin
      cyc(1'b1, 1'b1, 8'h99, 1'b0);
      idle(6);
    end
    cyc(1'b0, 1'b1, 8'h98, 1'b0);
    idle(6);
    checks++;
    if (dut_value() !== 999998 || dut_value() !== m_val || sat !== 1'b0) begin
      errors++;
      $display("FAIL ramp: got %0d sat=%b exp 999998 sat=0",
               dut_value(), sat);
    end
    cyc(1'b0, 1'b1, 8'h05, 1'b0);
    idle(6);
`ifdef SCORE_SATURATE_EN
    exp_v = 999999;
`else
    exp_v = 3;
`endif
    checks++;
    if (dut_value() !== exp_v || sat !== 1'b1 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow: got %0d sat=%b exp %0d sat=1",
               dut_value(), sat, exp_v);
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
`ifdef SCORE_SATURATE_EN
    exp_v = 999999;
    checks++;
    if (dut_value() !== exp_v || sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got %0d sat=%b exp %0d sat=1",
               dut_value(), sat, exp_v);
    end
`else
    exp_v = 4;
    checks++;
    if (dut_value() !== exp_v || sat !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse: got %0d sat=%b exp %0d sat=0",
               dut_value(), sat, exp_v);
    end
`endif
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (dut_value() !== 0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %0d sat=%b exp 0 sat=0", dut_value(), sat);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    en1       = 1'b0;
    en2       = 1'b0;
    tick      = 1'b0;
    ifc.valid = 1'b0;
    ifc.bcd   = 8'h00;
    model_reset();
    test_reset();
    test_tick();
    test_add_basic();
    test_pending();
    test_clamp();
    test_clear_mid();
    test_reset_mid();
    test_random();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
